// File: rtl/branch_predictor_ctrl.sv
// Bimodal branch predictor with misprediction-recovery sequencing.
// Keeps ENTRIES 2-bit saturating counters indexed by PC[log2(ENTRIES)+1:2],
// predicts combinationally for fetch, trains on resolved conditional branches,
// and on a mispredict issues one redirect pulse followed by FLUSH_CYCLES of flush.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   fetch_pc            PC being fetched; pred_taken is its combinational prediction
//   resolve_*           resolved instruction from execute (valid, is_branch, pc,
//                       taken, carried prediction, target)
//   redirect_valid/pc   one-cycle redirect to the PC unit (pc is 0 when not valid)
//   flush               kill younger instructions while recovering
//   branch_count        accepted conditional branches (wraps)
//   mispredict_count    accepted mispredictions (wraps)
module branch_predictor_ctrl #(
    parameter int unsigned ENTRIES      = 64,
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc,
    output logic            pred_taken,
    input  logic            resolve_valid,
    input  logic            resolve_is_branch,
    input  logic [XLEN-1:0] resolve_pc,
    input  logic            resolve_taken,
    input  logic            resolve_pred_taken,
    input  logic [XLEN-1:0] resolve_target,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush,
    output logic [31:0]     branch_count,
    output logic [31:0]     mispredict_count
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       pht [ENTRIES];

    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] resolve_idx;
    logic             accepted;
    logic             mispredict;
    logic             unused_fetch_bits;

    assign fetch_idx   = fetch_pc[IDX_W+1:2];
    assign resolve_idx = resolve_pc[IDX_W+1:2];

    // Prediction reads the pre-update counter; same-cycle writes land next cycle.
    assign pred_taken = pht[fetch_idx][1];

    // Resolves during recovery belong to the flushed path and are dropped.
    assign accepted   = resolve_valid & resolve_is_branch & (state == S_IDLE);
    assign mispredict = accepted & (resolve_taken != resolve_pred_taken);

    // Fetch PC bits outside the index field do not participate in prediction.
    assign unused_fetch_bits = ^{fetch_pc[XLEN-1:IDX_W+2], fetch_pc[1:0]};

    // Pattern history table: saturating 2-bit counters, reset weakly not-taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                pht[i] <= 2'b01;
            end
        end else if (accepted) begin
            if (resolve_taken) begin
                if (pht[resolve_idx] != 2'b11) begin
                    pht[resolve_idx] <= pht[resolve_idx] + 2'd1;
                end
            end else begin
                if (pht[resolve_idx] != 2'b00) begin
                    pht[resolve_idx] <= pht[resolve_idx] - 2'd1;
                end
            end
        end
    end

    // Recovery FSM with registered redirect/flush outputs and statistics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            flush_cnt        <= '0;
            flush            <= 1'b0;
            redirect_valid   <= 1'b0;
            redirect_pc      <= '0;
            branch_count     <= 32'd0;
            mispredict_count <= 32'd0;
        end else begin
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            if (accepted) begin
                branch_count <= branch_count + 32'd1;
            end
            case (state)
                S_IDLE: begin
                    if (mispredict) begin
                        mispredict_count <= mispredict_count + 32'd1;
                        redirect_valid   <= 1'b1;
                        redirect_pc      <= resolve_taken ? resolve_target
                                                          : resolve_pc + XLEN'(4);
                        flush_cnt        <= CNT_W'(FLUSH_CYCLES - 1);
                        flush            <= 1'b1;
                        state            <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt == '0) begin
                        flush <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        flush_cnt <= flush_cnt - CNT_W'(1);
                    end
                end
                default: begin
                    flush <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Bench for branch_predictor_ctrl: two instances (FLUSH_CYCLES 2 and 1) share
// stimulus; a cycle-indexed reference model predicts every output each cycle.
module tb_branch_predictor_ctrl;

    localparam int unsigned ENTRIES = 64;
    localparam int unsigned XLEN    = 32;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        resolve_valid;
    logic        resolve_is_branch;
    logic [31:0] resolve_pc;
    logic        resolve_taken;
    logic        resolve_pred_taken;
    logic [31:0] resolve_target;

    logic        pt  [2];
    logic        rv  [2];
    logic [31:0] rpc [2];
    logic        fl  [2];
    logic [31:0] bc  [2];
    logic [31:0] mc  [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    branch_predictor_ctrl #(.ENTRIES(ENTRIES), .XLEN(XLEN), .FLUSH_CYCLES(2)) u_dut2 (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pt[0]),
        .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
        .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_pred_taken(resolve_pred_taken), .resolve_target(resolve_target),
        .redirect_valid(rv[0]), .redirect_pc(rpc[0]), .flush(fl[0]),
        .branch_count(bc[0]), .mispredict_count(mc[0])
    );

    branch_predictor_ctrl #(.ENTRIES(ENTRIES), .XLEN(XLEN), .FLUSH_CYCLES(1)) u_dut1 (
        .clk(clk), .rst(rst), .fetch_pc(fetch_pc), .pred_taken(pt[1]),
        .resolve_valid(resolve_valid), .resolve_is_branch(resolve_is_branch),
        .resolve_pc(resolve_pc), .resolve_taken(resolve_taken),
        .resolve_pred_taken(resolve_pred_taken), .resolve_target(resolve_target),
        .redirect_valid(rv[1]), .redirect_pc(rpc[1]), .flush(fl[1]),
        .branch_count(bc[1]), .mispredict_count(mc[1])
    );

    // Reference model: counters as plain integers, recovery as a time window.
    int          m_fc  [2] = '{2, 1};
    int          m_pht [2][ENTRIES];
    int unsigned m_bc  [2];
    int unsigned m_mc  [2];
    longint      m_mis [2];
    logic [31:0] m_rpc [2];
    longint      cyc;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", tag, cyc, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit in_flush(input int d);
        return (cyc >= m_mis[d] + 1) && (cyc <= m_mis[d] + m_fc[d]);
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < ENTRIES; i++) m_pht[d][i] = 1;
            m_bc[d]  = 0;
            m_mc[d]  = 0;
            m_mis[d] = -1000;
            m_rpc[d] = '0;
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 2; d++) begin
            bit fw = in_flush(d);
            bit rw = (cyc == m_mis[d] + 1);
            check_eq($sformatf("pred_taken[%0d]", d), 64'(pt[d]), 64'(m_pht[d][idx_of(fetch_pc)] >= 2));
            check_eq($sformatf("redirect_valid[%0d]", d), 64'(rv[d]), 64'(rw));
            check_eq($sformatf("redirect_pc[%0d]", d), 64'(rpc[d]), 64'(rw ? m_rpc[d] : 32'd0));
            check_eq($sformatf("flush[%0d]", d), 64'(fl[d]), 64'(fw));
            check_eq($sformatf("branch_count[%0d]", d), 64'(bc[d]), 64'(m_bc[d]));
            check_eq($sformatf("mispredict_count[%0d]", d), 64'(mc[d]), 64'(m_mc[d]));
        end
    endtask

    task automatic model_update();
        if (rst) begin
            model_reset();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (!in_flush(d) && resolve_valid && resolve_is_branch) begin
                    int i = idx_of(resolve_pc);
                    if (resolve_taken) m_pht[d][i] = (m_pht[d][i] < 3) ? m_pht[d][i] + 1 : 3;
                    else               m_pht[d][i] = (m_pht[d][i] > 0) ? m_pht[d][i] - 1 : 0;
                    m_bc[d]++;
                    if (resolve_taken != resolve_pred_taken) begin
                        m_mc[d]++;
                        m_mis[d] = cyc;
                        m_rpc[d] = resolve_taken ? resolve_target : resolve_pc + 32'd4;
                    end
                end
            end
        end
        cyc++;
    endtask

    // One clock: check this cycle's outputs, clock the model, release inputs.
    task automatic step();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_cycles(input int n);
        resolve_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic resolve(input logic [31:0] pc, input logic tk, input logic pr,
                           input logic [31:0] tgt);
        resolve_valid      = 1'b1;
        resolve_is_branch  = 1'b1;
        resolve_pc         = pc;
        resolve_taken      = tk;
        resolve_pred_taken = pr;
        resolve_target     = tgt;
        step();
        resolve_valid = 1'b0;
    endtask

    function automatic logic model_pred(input logic [31:0] pc);
        return logic'(m_pht[0][idx_of(pc)] >= 2);
    endfunction

    initial begin
        logic [31:0] pc;
        logic        tk;
        cyc                = 0;
        rst                = 1'b1;
        fetch_pc           = '0;
        resolve_valid      = 1'b0;
        resolve_is_branch  = 1'b0;
        resolve_pc         = '0;
        resolve_taken      = 1'b0;
        resolve_pred_taken = 1'b0;
        resolve_target     = '0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Sweep all indices after reset.
        for (int i = 0; i < ENTRIES; i++) begin
            fetch_pc = 32'(i) << 2;
            step();
        end

        // Taken mispredict at 0x100 -> redirect to 0x200.
        fetch_pc = 32'h100;
        resolve(32'h100, 1'b1, 1'b0, 32'h200);
        check_eq("dir_redirect_valid", 64'(rv[0]), 64'd1);
        check_eq("dir_redirect_pc", 64'(rpc[0]), 64'h200);
        check_eq("dir_pred_0x100", 64'(pt[0]), 64'd1);
        idle_cycles(3);
        check_eq("dir_mispredict_count", 64'(mc[0]), 64'd1);
        check_eq("dir_branch_count", 64'(bc[0]), 64'd1);

        // Not-taken mispredict at top of address space wraps to 0.
        resolve(32'hFFFF_FFFC, 1'b0, 1'b1, 32'h1234);
        check_eq("dir_wrap_pc", 64'(rpc[0]), 64'h0);
        idle_cycles(3);

        // Saturation: four taken then four not-taken at one PC.
        fetch_pc = 32'h300;
        for (int k = 0; k < 4; k++) begin
            resolve(32'h300, 1'b1, model_pred(32'h300), 32'h400);
            idle_cycles(3);
        end
        for (int k = 0; k < 4; k++) begin
            resolve(32'h300, 1'b0, model_pred(32'h300), 32'h400);
            idle_cycles(3);
        end
        check_eq("dir_sat_low", 64'(pt[0]), 64'd0);

        // Resolves during flush are dropped; first IDLE cycle is accepted.
        resolve(32'h500, 1'b1, 1'b0, 32'h600);
        resolve(32'h504, 1'b1, 1'b0, 32'h700);
        resolve(32'h508, 1'b0, 1'b1, 32'h800);
        resolve(32'h50C, 1'b0, 1'b0, 32'h900);
        idle_cycles(3);

        // Reset in first flush cycle.
        resolve(32'h600, 1'b1, 1'b0, 32'hA00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("dir_rst_flush", 64'(fl[0]), 64'd0);
        check_eq("dir_rst_count", 64'(bc[0]), 64'd0);
        idle_cycles(2);

        // Randomized traffic over a small PC pool to force index collisions.
        for (int n = 0; n < 3000; n++) begin
            pc                 = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 1)) << 31);
            tk                 = 1'($urandom_range(0, 1));
            resolve_valid      = ($urandom_range(0, 3) != 0);
            resolve_is_branch  = ($urandom_range(0, 4) != 0);
            resolve_pc         = pc;
            resolve_taken      = tk;
            resolve_pred_taken = ($urandom_range(0, 2) == 0) ? ~tk : tk;
            resolve_target     = $urandom;
            fetch_pc           = (32'($urandom_range(0, 15)) << 2) | (32'($urandom) & 32'hFFFF_FF00);
            rst                = ($urandom_range(0, 99) == 0);
            step();
        end
        rst = 1'b0;
        idle_cycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
